// File: rtl/adder_pkg.sv
// Shared types and helpers for the 4-bit adder slice.
// Operand/sum type and the signed-overflow rule used by the flag logic.
package adder_pkg;

  localparam int WIDTH = 4;

  typedef logic [3:0] nibble_t;

  // Two's-complement overflow: operands share a sign that the sum does not.
  function automatic logic calc_ovf(input nibble_t a, input nibble_t b, input nibble_t s);
    calc_ovf = (a[3] == b[3]) && (s[3] != a[3]);
  endfunction

endpackage

// File: rtl/binary_adder_4bit_full_adder.sv
// Single-bit full adder, one stage of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/binary_adder_4bit.sv
// 4-bit unsigned ripple-carry adder with combinational result/flags
// and a registered copy cleared by an asynchronous active-high reset.
module binary_adder_4bit
  import adder_pkg::*;
#(
  parameter int WIDTH = adder_pkg::WIDTH
) (
  input  logic    clk,
  input  logic    rst,
  input  nibble_t A,
  input  nibble_t B,
  output nibble_t SUM,
  output logic    COUT,
  output logic    OVF,
  output logic    ZERO,
  output nibble_t SUM_Q,
  output logic    COUT_Q,
  output logic    OVF_Q,
  output logic    ZERO_Q
);

  logic [WIDTH:0] carry_s;
  nibble_t        sum_s;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry_s[i]),
      .s    (sum_s[i]),
      .cout (carry_s[i+1])
    );
  end

  assign SUM  = sum_s;
  assign COUT = carry_s[WIDTH];
  assign OVF  = calc_ovf(A, B, sum_s);
  assign ZERO = (sum_s == 4'h0);

  // Registered result and flags; reset state matches a zero sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SUM_Q  <= 4'h0;
      COUT_Q <= 1'b0;
      OVF_Q  <= 1'b0;
      ZERO_Q <= 1'b1;
    end else begin
      SUM_Q  <= SUM;
      COUT_Q <= COUT;
      OVF_Q  <= OVF;
      ZERO_Q <= ZERO;
    end
  end

endmodule

// File: tb/tb_binary_adder_4bit.sv
// Directed and exhaustive self-checking bench for binary_adder_4bit.
module tb_binary_adder_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] a_s;
  logic [3:0] b_s;
  logic [3:0] sum_s;
  logic       cout_s;
  logic       ovf_s;
  logic       zero_s;
  logic [3:0] sum_q_s;
  logic       cout_q_s;
  logic       ovf_q_s;
  logic       zero_q_s;

  int n_checks;
  int n_fail;

  binary_adder_4bit dut (
    .clk    (clk),
    .rst    (rst),
    .A      (a_s),
    .B      (b_s),
    .SUM    (sum_s),
    .COUT   (cout_s),
    .OVF    (ovf_s),
    .ZERO   (zero_s),
    .SUM_Q  (sum_q_s),
    .COUT_Q (cout_q_s),
    .OVF_Q  (ovf_q_s),
    .ZERO_Q (zero_q_s)
  );

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One full clock period: rising edge now, falling edge 5 later.
  task automatic pulse_clk();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  task automatic check_q(input string tag, input logic [3:0] s, input logic c,
                         input logic o, input logic z);
    check_val({tag, ".sum_q"},  {4'h0, sum_q_s}, {4'h0, s});
    check_val({tag, ".cout_q"}, {7'h0, cout_q_s}, {7'h0, c});
    check_val({tag, ".ovf_q"},  {7'h0, ovf_q_s}, {7'h0, o});
    check_val({tag, ".zero_q"}, {7'h0, zero_q_s}, {7'h0, z});
  endtask

  task automatic check_comb(input string tag, input logic [3:0] s, input logic c,
                            input logic o, input logic z);
    check_val({tag, ".sum"},  {4'h0, sum_s}, {4'h0, s});
    check_val({tag, ".cout"}, {7'h0, cout_s}, {7'h0, c});
    check_val({tag, ".ovf"},  {7'h0, ovf_s}, {7'h0, o});
    check_val({tag, ".zero"}, {7'h0, zero_s}, {7'h0, z});
  endtask

  initial begin
    int exp_sum;
    int sa;
    int sb;
    logic exp_ovf;
    n_checks = 0;
    n_fail   = 0;
    clk = 1'b0;
    rst = 1'b1;
    a_s = 4'h0;
    b_s = 4'h0;
    #10;
    check_q("reset", 4'h0, 1'b0, 1'b0, 1'b1);
    check_comb("zero_in", 4'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    #10;

    // Combinational path with no clock activity.
    a_s = 4'b0011; b_s = 4'b0101; #10;
    check_comb("3p5", 4'b1000, 1'b0, 1'b1, 1'b0);
    a_s = 4'hF; b_s = 4'h1; #10;
    check_comb("fp1", 4'h0, 1'b1, 1'b0, 1'b1);

    // Exhaustive sweep; overflow judged from the signed value range.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a_s = i[3:0];
        b_s = j[3:0];
        #10;
        exp_sum = i + j;
        sa = (i > 7) ? i - 16 : i;
        sb = (j > 7) ? j - 16 : j;
        exp_ovf = ((sa + sb) > 7) || ((sa + sb) < -8);
        check_val("sweep.sum", {3'h0, cout_s, sum_s}, exp_sum[7:0]);
        check_val("sweep.ovf", {7'h0, ovf_s}, {7'h0, exp_ovf});
        check_val("sweep.zero", {7'h0, zero_s}, {7'h0, (exp_sum[3:0] == 4'h0)});
      end
    end

    // Registered path: unchanged until the edge, then one-cycle copy.
    a_s = 4'h7; b_s = 4'h2; #10;
    check_q("pre_edge", 4'h0, 1'b0, 1'b0, 1'b1);
    pulse_clk();
    check_q("7p2_q", 4'h9, 1'b0, 1'b1, 1'b0);

    a_s = 4'hF; b_s = 4'hF; #5;
    pulse_clk();
    check_q("fpf_q", 4'hE, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle, combinational outputs unaffected.
    #2; rst = 1'b1; #1;
    check_q("async_rst", 4'h0, 1'b0, 1'b0, 1'b1);
    check_comb("rst_comb", 4'hE, 1'b1, 1'b0, 1'b0);
    pulse_clk();
    check_q("rst_hold", 4'h0, 1'b0, 1'b0, 1'b1);

    rst = 1'b0; #5;
    pulse_clk();
    check_q("release", 4'hE, 1'b1, 1'b0, 1'b0);

    // Reset coinciding with a rising edge must win.
    a_s = 4'h1; b_s = 4'h1; #5;
    rst = 1'b1;
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #1;
    check_q("rst_vs_edge", 4'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0; #4;
    pulse_clk();
    check_q("after_coinc", 4'h2, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/binary_adder_4bit.md
# binary_adder_4bit

4-bit unsigned ripple-carry adder. Combinational sum and carry outputs, plus a registered copy of the result with status flags. Used as a leaf arithmetic block in datapath logic and as a formal-verification target. The combinational path does not depend on the clock or reset, so it is correct with clk/rst left undriven.

## Interface
- WIDTH, 4, operand width; only 4 is supported and verified.
- clk  input  1  rising-edge clock for the registered outputs only.
- rst  input  1  asynchronous, active-high reset; clears registered outputs.
- A  input  4  operand A, unsigned.
- B  input  4  operand B, unsigned.
- SUM  output  4  combinational (A + B) mod 16.
- COUT  output  1  combinational carry out, bit 4 of A + B.
- OVF  output  1  combinational two's-complement overflow: (A[3] == B[3]) && (SUM[3] != A[3]).
- ZERO  output  1  combinational, 1 when SUM == 0.
- SUM_Q  output  4  registered SUM.
- COUT_Q  output  1  registered COUT.
- OVF_Q  output  1  registered OVF.
- ZERO_Q  output  1  registered ZERO.

## Operation
- {COUT, SUM} = A + B as a 5-bit unsigned result; no carry-in.
- Implementation is a ripple chain of 4 full adders.
  - Stage 0 carry-in is constant 0.
  - c[i+1] = a&b | a&c[i] | b&c[i]; s[i] = a^b^c[i]; COUT = c[4].
- OVF and ZERO are derived from the same combinational result.
- Registered outputs capture SUM, COUT, OVF and ZERO on every rising clk edge when rst = 0. There is no enable.
- X or Z on any A/B bit may propagate as X on the outputs; no X-masking is performed.

## Timing
- SUM/COUT/OVF/ZERO: zero-cycle latency. Outputs are valid one combinational settle after A/B change.
  - Settle is required within 10 time units in simulation.
  - Outputs change with no clock present.
- *_Q outputs: one-cycle latency. The value sampled at rising edge n appears after edge n and holds until edge n+1.
- Reset values: SUM_Q = 4'h0, COUT_Q = 0, OVF_Q = 0, ZERO_Q = 1 (consistent with a zero sum).
- rst is asynchronous:
  - Assertion clears all *_Q immediately, mid-cycle.
  - Combinational outputs are unaffected by rst.
- Release of rst is synchronous in effect. The first capture happens at the first rising edge after rst falls.
- If rst and a rising edge coincide, reset wins.
- Boundaries:
  - A = B = 4'hF gives {COUT, SUM} = 5'h1E.
  - 4'hF + 4'h1 wraps: SUM = 0, COUT = 1, ZERO = 1.

## Structure
- Shared package (adder_pkg):
  - WIDTH = 4 localparam.
  - typedef logic [3:0] nibble_t for operands and sum.
  - Function calc_ovf(a, b, s).
- Sub-module full_adder: inputs a, b, cin; outputs s, cout. Instantiated 4 times via generate.
- Top level contains:
  - The carry chain.
  - Flag logic.
  - One always_ff block with asynchronous reset for the *_Q registers.

## Test plan
- A = 4'b0011, B = 4'b0101, wait 10 with no clock -> SUM = 4'b1000, COUT = 0, OVF = 1, ZERO = 0.
- A = 4'hF, B = 4'h1 -> SUM = 4'h0, COUT = 1, ZERO = 1, OVF = 0.
- Exhaustive sweep of all 256 A/B pairs -> {COUT, SUM} == A + B every time; OVF matches the signed-overflow formula.
- A = 4'h7, B = 4'h2, clock one edge -> SUM_Q = 4'h9, COUT_Q = 0, OVF_Q = 1 after the edge; *_Q unchanged before the edge.
- A = 4'hF, B = 4'hF, registered, then assert rst mid-cycle -> *_Q go to 0/0/0/1 immediately while SUM = 4'hE and COUT = 1 persist.
- Release rst, then one edge -> SUM_Q = 4'hE, COUT_Q = 1.
